// File: rtl/screen_scheduler.sv
// Shares the VGA colour output among four full-screen renderers with frame-aligned,
// priority-driven screen switching, a minimum hold time and a per-frame brightness fade.
module screen_scheduler #(
    parameter int unsigned MIN_HOLD_FRAMES = 60,
    parameter int unsigned HOLD_W          = 8
) (
    input  logic        vga_clk,
    input  logic        reset,
    input  logic [9:0]  DrawX,
    input  logic [9:0]  DrawY,
    input  logic        blank,
    input  logic [3:0]  req,
    input  logic [47:0] src_rgb,
    output logic [3:0]  red,
    output logic [3:0]  green,
    output logic [3:0]  blue,
    output logic [1:0]  sel,
    output logic        screen_start,
    output logic        fading
);

    localparam int unsigned LEVEL_W = 5;
    localparam logic [LEVEL_W-1:0] LEVEL_FULL = LEVEL_W'(16);
    localparam logic [LEVEL_W-1:0] LEVEL_ONE  = LEVEL_W'(1);
    localparam logic [HOLD_W-1:0]  HOLD_MIN   = HOLD_W'(MIN_HOLD_FRAMES);
    localparam logic [1:0]         SCR_GAME   = 2'd0;
    localparam logic [1:0]         SCR_JUMP   = 2'd1;
    localparam logic [1:0]         SCR_WIN    = 2'd2;
    localparam logic [1:0]         SCR_LOSE   = 2'd3;

    typedef enum logic [1:0] {
        SHOW     = 2'd0,
        FADE_OUT = 2'd1,
        FADE_IN  = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [1:0]          sel_q, sel_d;
    logic [LEVEL_W-1:0]  level_q, level_d;
    logic [HOLD_W-1:0]   hold_q, hold_d;
    logic [3:0]          red_q, red_d, green_q, green_d, blue_q, blue_d;
    logic                screen_start_q, screen_start_d;
    logic                fading_q, fading_d;

    logic       frame_tick;
    logic [1:0] target;
    logic [11:0] pix;

    // Channel scaled by level/16; the product never exceeds 8 bits (15*16).
    function automatic logic [3:0] scale(input logic [3:0] c, input logic [LEVEL_W-1:0] l);
        logic [7:0] p;
        p = 8'(c) * 8'(l);
        return 4'(p >> 4);
    endfunction

    assign frame_tick = (DrawX == 10'd0) && (DrawY == 10'd0);

    always_comb begin
        if (req[1])      target = SCR_JUMP;
        else if (req[3]) target = SCR_LOSE;
        else if (req[2]) target = SCR_WIN;
        else             target = SCR_GAME;
    end

    // Next-state logic; a jumpscare cut bypasses hold, fade and frame alignment.
    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        level_d = level_q;
        hold_d  = hold_q;
        if (target == SCR_JUMP && sel_q != SCR_JUMP) begin
            sel_d   = SCR_JUMP;
            level_d = LEVEL_FULL;
            hold_d  = '0;
            state_d = SHOW;
        end else if (frame_tick) begin
            case (state_q)
                SHOW: begin
                    if (hold_q != '1) hold_d = hold_q + HOLD_W'(1);
                    if (target != sel_q && hold_q >= HOLD_MIN) state_d = FADE_OUT;
                end
                FADE_OUT: begin
                    if (target == sel_q) begin
                        state_d = FADE_IN;
                    end else if (level_q == LEVEL_ONE) begin
                        level_d = '0;
                        sel_d   = target;
                        hold_d  = '0;
                        state_d = FADE_IN;
                    end else begin
                        level_d = level_q - LEVEL_ONE;
                    end
                end
                FADE_IN: begin
                    level_d = level_q + LEVEL_ONE;
                    if (level_d == LEVEL_FULL) state_d = SHOW;
                end
                default: state_d = SHOW;
            endcase
        end
    end

    // Output stage follows the post-edge selection so a cut shows the new screen at once.
    always_comb begin
        case (sel_d)
            SCR_GAME: pix = src_rgb[11:0];
            SCR_JUMP: pix = src_rgb[23:12];
            SCR_WIN:  pix = src_rgb[35:24];
            default:  pix = src_rgb[47:36];
        endcase
        red_d   = '0;
        green_d = '0;
        blue_d  = '0;
        if (blank) begin
            red_d   = scale(pix[11:8], level_d);
            green_d = scale(pix[7:4], level_d);
            blue_d  = scale(pix[3:0], level_d);
        end
        screen_start_d = (sel_d != sel_q);
        fading_d       = (state_d != SHOW);
    end

    always_ff @(posedge vga_clk or posedge reset) begin
        if (reset) begin
            state_q        <= SHOW;
            sel_q          <= SCR_GAME;
            level_q        <= LEVEL_FULL;
            hold_q         <= '0;
            red_q          <= '0;
            green_q        <= '0;
            blue_q         <= '0;
            screen_start_q <= 1'b0;
            fading_q       <= 1'b0;
        end else begin
            state_q        <= state_d;
            sel_q          <= sel_d;
            level_q        <= level_d;
            hold_q         <= hold_d;
            red_q          <= red_d;
            green_q        <= green_d;
            blue_q         <= blue_d;
            screen_start_q <= screen_start_d;
            fading_q       <= fading_d;
        end
    end

    assign red          = red_q;
    assign green        = green_q;
    assign blue         = blue_q;
    assign sel          = sel_q;
    assign screen_start = screen_start_q;
    assign fading       = fading_q;

endmodule
